// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry add/subtract: one SEG-bit ripple segment per stage,
// carry registered between segments, valid/ready on both sides.
module rca_pipe_addsub #(
    parameter int BW  = 16,
    parameter int SEG = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic [1:0]    op,
    input  logic          cin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] sum,
    output logic          cout,
    output logic          ov,
    output logic          zero,
    output logic          neg
);
    localparam int NSEG = BW / SEG;

    logic [BW-1:0]   y_in;
    logic            c0;
    logic [NSEG-1:0] vld;
    logic [NSEG-1:0] cry;
    logic [NSEG-1:0] adv;
    logic            ov_q;

    assign y_in = op[1] ? ~b : b;
    assign c0   = op[0] ? cin : op[1];

    // A stage may load when every stage downstream of it can move or is empty.
    always_comb begin
        logic acc;
        acc = out_ready;
        adv = '0;
        for (int k = NSEG - 1; k >= 0; k--) begin
            acc    = acc | ~vld[k];
            adv[k] = acc;
        end
    end

    for (genvar g = 0; g < NSEG; g++) begin : st
        localparam int LO = g * SEG;
        localparam int HI = LO + SEG;

        logic           vi;
        logic           ci;
        logic           v;
        logic           c;
        logic [BW-1:LO] ai;
        logic [BW-1:LO] yi;
        logic [HI-1:0]  sn;
        logic [HI-1:0]  s;
        logic [SEG:0]   t;

        if (g == 0) begin : src
            assign vi = in_valid;
            assign ci = c0;
            assign ai = a;
            assign yi = y_in;
            assign sn = t[SEG-1:0];
        end else begin : src
            assign vi = vld[g-1];
            assign ci = cry[g-1];
            assign ai = st[g-1].up.ua;
            assign yi = st[g-1].up.uy;
            assign sn = {t[SEG-1:0], st[g-1].s};
        end

        assign t = {1'b0, ai[HI-1:LO]}
                 + {1'b0, yi[HI-1:LO]}
                 + {{SEG{1'b0}}, ci};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                s <= '0;
                c <= 1'b0;
            end else if (adv[g]) begin
                v <= vi;
                if (vi) begin
                    s <= sn;
                    c <= t[SEG];
                end
            end
        end

        assign vld[g] = v;
        assign cry[g] = c;

        if (g < NSEG - 1) begin : up
            logic [BW-1:HI] ua;
            logic [BW-1:HI] uy;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ua <= '0;
                    uy <= '0;
                end else if (adv[g] && vi) begin
                    ua <= ai[BW-1:HI];
                    uy <= yi[BW-1:HI];
                end
            end
        end else begin : fin
            // Carry into the MSB recovered from its sum bit and operand bits.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ov_q <= 1'b0;
                end else if (adv[g] && vi) begin
                    ov_q <= t[SEG-1] ^ ai[HI-1] ^ yi[HI-1] ^ t[SEG];
                end
            end

            assign out_valid = v;
            assign sum       = s;
            assign cout      = c;
        end
    end

    assign ov       = ov_q;
    assign zero     = out_valid & ~|sum;
    assign neg      = sum[BW-1];
    assign in_ready = adv[0];

endmodule
